imem_fetch_unit: RTL
====================

Name: imem_fetch_unit

Overview:
Parametrised successor to the fixed instruction ROM. It provides word-addressed instruction storage with a byte-address fetch port, one-cycle synchronous read and a valid/ready handshake on both request and response. It adds a runtime program-load write port, hardware clear-to-NOP after reset, and misalignment/range error reporting. It sits between the PC/fetch stage and decode.

Parameters:
DATA_W, 32, instruction word width in bits
ADDR_W, 8, byte-address width of fetch_addr/prog_addr
DEPTH, 64, number of words stored; must be <= 2**(ADDR_W-2)
NOP_WORD, 32'h0000_0000, word written during init and returned on errored fetch

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
fetch_valid  in  1  fetch request valid
fetch_ready  out  1  fetch request accepted when fetch_valid && fetch_ready
fetch_addr  in  ADDR_W  byte address of the requested instruction
instr_valid  out  1  response valid
instr_ready  in  1  consumer accepts the response
instr_data  out  DATA_W  fetched instruction
instr_addr_err  out  1  response flag: misaligned or out-of-range fetch
instr_par_err  out  1  response flag: parity mismatch (see Optional Feature)
prog_we  in  1  program-load write strobe
prog_addr  in  ADDR_W  byte address for the write
prog_data  in  DATA_W  word to store
init_done  out  1  high once the post-reset clear has finished

Behaviour:
- Reset values: fetch_ready=0, instr_valid=0, instr_data=0, instr_addr_err=0, instr_par_err=0, init_done=0, FSM=INIT, init counter=0.
- FSM states:
  - INIT: writes NOP_WORD to word[cnt] and increments cnt each cycle. After the write to word DEPTH-1 the FSM goes to RUN and sets init_done=1, i.e. exactly DEPTH cycles after rst deasserts. prog_we and fetch are ignored and fetch_ready=0 throughout.
  - RUN: terminal until the next reset.
- Word index = addr >> 2.
  - Misaligned: addr[1:0] != 0.
  - Out of range: index >= DEPTH.
- Single storage port. Priority is INIT > prog write > fetch.
- fetch_ready = (state==RUN) && !prog_we && (!instr_valid || instr_ready). It is combinational on prog_we and instr_ready.
- Fetch accepted in cycle N:
  - In cycle N+1: instr_valid=1, instr_data=word[index], instr_addr_err=0.
  - If misaligned or out of range: instr_data=NOP_WORD, instr_addr_err=1, and the storage is not read.
- A response is held stable (data and flags) while instr_valid && !instr_ready.
- instr_valid drops the cycle after the handshake unless a new fetch was accepted in the same cycle.
- Throughput: one fetch per cycle with instr_ready held high.
- Prog write in RUN:
  - Written at the clock edge.
  - Misaligned or out-of-range writes are dropped silently.
  - A fetch of the same word accepted in any later cycle returns the new data; there is no stale read.
- Simultaneous prog_we and fetch_valid: the write wins and the fetch stalls one cycle (fetch_ready=0). The requester must hold fetch_valid/fetch_addr stable until accepted.
- Reset mid-operation: asynchronously discards any pending response and returns the FSM to INIT. Stored contents are re-cleared.

Optional Feature:
Macro IMEM_PARITY_EN.
- Defined:
  - Each word stores an extra even-parity bit computed on write (init, prog).
  - On fetch, parity is recomputed. instr_par_err=1 on mismatch, returned alongside the response with the same hold rules.
  - Errored-address responses report par_err=0.
- Undefined: no parity storage; instr_par_err is tied 0.

Decomposition:
- Package imem_pkg: state enum (INIT, RUN), NOP constant default, functions word_index() and addr_fault() (misaligned or out of range), and parity function.
- Sub-module imem_array: a single-port synchronous RAM (we, addr, wdata, rdata; width DATA_W+parity, depth DEPTH) holding the storage.
- The top holds the FSM, arbitration, response register and error logic.

Test Plan:
- Init: release rst, hold fetch_valid=1 at 0x10 -> fetch_ready=0 for 64 cycles; init_done rises at cycle 64; first response instr_data=0x00000000, err=0.
- Program then fetch: prog 0x04<=0xAC410000, then fetch 0x04 -> instr_valid next cycle with 0xAC410000, instr_addr_err=0.
- Back-to-back and backpressure: fetch 0x00,0x04,0x08 with instr_ready=1 -> 3 responses on 3 consecutive cycles. Then drop instr_ready for 3 cycles -> data held, fetch_ready=0; resume without loss or duplication.
- Errors: fetch 0x06 -> instr_data=NOP_WORD, instr_addr_err=1. With DEPTH=32, fetch 0x80 -> instr_addr_err=1. prog 0x06 -> memory unchanged.
- Collision: prog_we at 0x08 (0x08000005) in the same cycle as fetch_valid at 0x08 -> fetch_ready=0 that cycle; the fetch is accepted next cycle and returns 0x08000005.
- Reset mid-stream: assert rst with instr_valid=1 -> instr_valid=0 immediately. After release, INIT reruns and a previously programmed word reads 0. With IMEM_PARITY_EN, force a flipped stored bit -> instr_par_err=1.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared types and helpers for the instruction memory fetch unit.
// Optional parity storage is enabled with IMEM_PARITY_EN.
package imem_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Widest address/data handled by the helpers; callers zero-extend.
  localparam int MAX_W = 64;

  localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;

  function automatic logic [MAX_W-1:0] word_index(input logic [MAX_W-1:0] addr);
    return addr >> 2;
  endfunction

  function automatic logic addr_fault(input logic [MAX_W-1:0] addr,
                                      input int unsigned      depth);
    return (addr[1:0] != 2'b00) || ((addr >> 2) >= MAX_W'(depth));
  endfunction

  // Even parity: returns the bit that makes the total count of ones even.
  function automatic logic parity(input logic [MAX_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/imem_fetch_unit_array.sv
// Single-port synchronous RAM for instruction storage; read data is registered
// and holds its value on cycles with no read.
module imem_array #(
  parameter int W     = 32,
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic          re_i,
  input  logic [AW-1:0] addr_i,
  input  logic [W-1:0]  wdata_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end else if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/imem_fetch_unit.sv
// Instruction memory with byte-address fetch port, program-load port and
// clear-to-NOP after reset. Define IMEM_PARITY_EN to store a parity bit per word.
module imem_fetch_unit
  import imem_pkg::*;
#(
  parameter int              DATA_W   = 32,
  parameter int              ADDR_W   = 8,
  parameter int              DEPTH    = 64,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_valid,
  output logic              fetch_ready,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_data,
  output logic              instr_addr_err,
  output logic              instr_par_err,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic              init_done
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef IMEM_PARITY_EN
  localparam int RAM_W = DATA_W + 1;
`else
  localparam int RAM_W = DATA_W;
`endif

  function automatic logic [RAM_W-1:0] pack_word(input logic [DATA_W-1:0] w);
`ifdef IMEM_PARITY_EN
    return {parity(MAX_W'(w)), w};
`else
    return w;
`endif
  endfunction

  state_e          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic            init_done_q, init_done_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;

  logic            fetch_fault, prog_fault, fetch_fire;
  logic [AW-1:0]   fetch_idx, prog_idx;
  logic            ram_we, ram_re;
  logic [AW-1:0]   ram_addr;
  logic [RAM_W-1:0] ram_wdata, ram_rdata;

  assign fetch_fault = addr_fault(MAX_W'(fetch_addr), DEPTH);
  assign prog_fault  = addr_fault(MAX_W'(prog_addr), DEPTH);
  assign fetch_idx   = AW'(word_index(MAX_W'(fetch_addr)));
  assign prog_idx    = AW'(word_index(MAX_W'(prog_addr)));
  assign fetch_fire  = fetch_valid && fetch_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_done_d = init_done_q;
    fetch_ready = 1'b0;
    ram_we      = 1'b0;
    ram_re      = 1'b0;
    ram_addr    = fetch_idx;
    ram_wdata   = pack_word(prog_data);

    case (state_q)
      INIT: begin
        ram_we    = 1'b1;
        ram_addr  = cnt_q;
        ram_wdata = pack_word(NOP_WORD);
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == AW'(DEPTH - 1)) begin
          state_d     = RUN;
          init_done_d = 1'b1;
          cnt_d       = '0;
        end
      end
      RUN: begin
        fetch_ready = !prog_we && (!valid_q || instr_ready);
        if (prog_we) begin
          // Faulting writes are dropped rather than aliased onto a legal word.
          if (!prog_fault) begin
            ram_we   = 1'b1;
            ram_addr = prog_idx;
          end
        end else if (fetch_fire && !fetch_fault) begin
          ram_re = 1'b1;
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_comb begin
    valid_d = valid_q && !instr_ready;
    err_d   = valid_d ? err_q : 1'b0;
    if (fetch_fire) begin
      valid_d = 1'b1;
      err_d   = fetch_fault;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= INIT;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
    end
  end

  imem_array #(
    .W     (RAM_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk     (clk),
    .we_i    (ram_we),
    .re_i    (ram_re),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  // The RAM output register only changes on a read, so it holds during backpressure.
  assign instr_valid    = valid_q;
  assign instr_addr_err = valid_q && err_q;
  assign instr_data     = valid_q ? (err_q ? NOP_WORD : ram_rdata[DATA_W-1:0]) : '0;
  assign init_done      = init_done_q;

`ifdef IMEM_PARITY_EN
  assign instr_par_err = valid_q && !err_q &&
                         (ram_rdata[DATA_W] != parity(MAX_W'(ram_rdata[DATA_W-1:0])));
`else
  assign instr_par_err = 1'b0;
`endif

endmodule
